// File: rtl/tile_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : tile_sequencer_if
//  Brief    : Command, operand, tile and response signals between the
//             mesh-level controller, the tile sequencer and one PE tile.
//             The sequencer uses the slave modport; the surrounding logic
//             (controller plus tile) uses the master modport.
//  Revision : 1.0 - initial release
// ============================================================================
interface tile_sequencer_if #(
   parameter int A_W     = 8,
   parameter int B_W     = 19,
   parameter int C_W     = 38,
   parameter int SHIFT_W = 4,
   parameter int LEN_W   = 8
);
   // command channel
   logic               cmd_valid;
   logic               cmd_ready;
   logic [LEN_W-1:0]   cmd_len;
   logic               cmd_preload;
   logic [SHIFT_W-1:0] cmd_shift;
   logic [C_W-1:0]     cmd_d;
   // operand channel
   logic               in_valid;
   logic               in_ready;
   logic [A_W-1:0]     in_a;
   logic [B_W-1:0]     in_b;
   // tile side
   logic [A_W-1:0]     tile_in_a;
   logic [B_W-1:0]     tile_in_b;
   logic [C_W-1:0]     tile_in_d;
   logic               tile_in_control_propagate;
   logic [SHIFT_W-1:0] tile_in_control_shift;
   logic               tile_in_valid;
   logic [C_W-1:0]     tile_out_c;
   logic               tile_out_valid;
   // response channel
   logic               resp_valid;
   logic               resp_ready;
   logic [C_W-1:0]     resp_c;
   logic [LEN_W-1:0]   resp_count;
   logic               resp_err;

   modport slave (
      input  cmd_valid, cmd_len, cmd_preload, cmd_shift, cmd_d,
      input  in_valid, in_a, in_b,
      input  tile_out_c, tile_out_valid,
      input  resp_ready,
      output cmd_ready, in_ready,
      output tile_in_a, tile_in_b, tile_in_d,
      output tile_in_control_propagate, tile_in_control_shift, tile_in_valid,
      output resp_valid, resp_c, resp_count, resp_err
   );

   modport master (
      output cmd_valid, cmd_len, cmd_preload, cmd_shift, cmd_d,
      output in_valid, in_a, in_b,
      output tile_out_c, tile_out_valid,
      output resp_ready,
      input  cmd_ready, in_ready,
      input  tile_in_a, tile_in_b, tile_in_d,
      input  tile_in_control_propagate, tile_in_control_shift, tile_in_valid,
      input  resp_valid, resp_c, resp_count, resp_err
   );
endinterface
`default_nettype wire

// File: rtl/tile_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tile_sequencer
//  Brief    : Sequences one systolic PE tile through a single command:
//             optional d preload (flipping propagate), a burst of a/b
//             compute beats, then a drain that waits for every in-flight
//             beat. Returns the last tile c, the compute beat count and a
//             drain-timeout flag.
//  Options  : TILE_SEQ_PERF_EN - adds perf_stall_cycles_o, a saturating
//             count of COMPUTE cycles with no operand offered.
//  Revision : 1.0 - initial release
// ============================================================================
module tile_sequencer #(
   parameter int A_W           = 8,
   parameter int B_W           = 19,
   parameter int C_W           = 38,
   parameter int SHIFT_W       = 4,
   parameter int LEN_W         = 8,
   parameter int DRAIN_TIMEOUT = 16
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   tile_sequencer_if.slave       bus_io,
   output logic                  busy_o
`ifdef TILE_SEQ_PERF_EN
   ,
   output logic [31:0]           perf_stall_cycles_o
`endif
);

   localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PRELOAD = 3'd1,
      S_COMPUTE = 3'd2,
      S_DRAIN   = 3'd3,
      S_RESP    = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [LEN_W-1:0]   len_q;
   logic [SHIFT_W-1:0] shift_q;
   logic [C_W-1:0]     d_q;
   logic               prop_q;
   logic [LEN_W-1:0]   beat_q;
   logic [LEN_W:0]     outst_q;
   logic [IDLE_W-1:0]  idle_q;
   logic [C_W-1:0]     c_q;
   logic               err_q;

   logic               w_accept;
   logic               w_beat;
   logic               w_inc;
   logic               w_dec;
   logic               w_timeout;
   logic               w_resp_done;
   logic [LEN_W-1:0]   w_beat_next;

   assign w_accept    = (state_q == S_IDLE) && bus_io.cmd_valid;
   assign w_beat      = (state_q == S_COMPUTE) && bus_io.in_valid;
   assign w_beat_next = beat_q + LEN_W'(1);
   assign w_inc       = bus_io.tile_in_valid;
   // A tile_out_valid with nothing in flight is spurious and is dropped.
   assign w_dec       = bus_io.tile_out_valid && (outst_q != '0);
   assign w_timeout   = (state_q == S_DRAIN) && (outst_q != '0) &&
                        !bus_io.tile_out_valid &&
                        (idle_q == IDLE_W'(DRAIN_TIMEOUT - 1));
   assign w_resp_done = (state_q == S_RESP) && bus_io.resp_ready;

   assign busy_o                           = (state_q != S_IDLE);
   assign bus_io.tile_in_control_shift     = shift_q;
   assign bus_io.tile_in_control_propagate = prop_q;

   // Next-state decode and all handshake/tile outputs.
   always_comb begin
      state_d              = state_q;
      bus_io.cmd_ready     = 1'b0;
      bus_io.in_ready      = 1'b0;
      bus_io.tile_in_a     = '0;
      bus_io.tile_in_b     = '0;
      bus_io.tile_in_d     = '0;
      bus_io.tile_in_valid = 1'b0;
      bus_io.resp_valid    = 1'b0;
      bus_io.resp_c        = '0;
      bus_io.resp_count    = '0;
      bus_io.resp_err      = 1'b0;
      case (state_q)
         S_IDLE: begin
            bus_io.cmd_ready = 1'b1;
            if (bus_io.cmd_valid) begin
               if (bus_io.cmd_preload)        state_d = S_PRELOAD;
               else if (bus_io.cmd_len != '0) state_d = S_COMPUTE;
               else                           state_d = S_RESP;
            end
         end
         S_PRELOAD: begin
            bus_io.tile_in_d     = d_q;
            bus_io.tile_in_valid = 1'b1;
            state_d = (len_q != '0) ? S_COMPUTE : S_DRAIN;
         end
         S_COMPUTE: begin
            bus_io.in_ready      = 1'b1;
            bus_io.tile_in_valid = bus_io.in_valid;
            bus_io.tile_in_a     = bus_io.in_a;
            bus_io.tile_in_b     = bus_io.in_b;
            if (bus_io.in_valid && (w_beat_next == len_q)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (outst_q == '0 || w_timeout) state_d = S_RESP;
         end
         S_RESP: begin
            bus_io.resp_valid = 1'b1;
            bus_io.resp_c     = c_q;
            bus_io.resp_count = beat_q;
            bus_io.resp_err   = err_q;
            if (bus_io.resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register plus the command fields latched on acceptance.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         shift_q <= '0;
         d_q     <= '0;
         prop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (w_accept) begin
            len_q   <= bus_io.cmd_len;
            shift_q <= bus_io.cmd_shift;
            d_q     <= bus_io.cmd_d;
            // Flip on the edge into PRELOAD so the preload beat already
            // carries the new propagate value.
            if (bus_io.cmd_preload) prop_q <= ~prop_q;
         end
      end
   end

   // Compute beat counter and error flag; both cleared by the response handshake.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         beat_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (w_beat)           beat_q <= w_beat_next;
         else if (w_resp_done) beat_q <= '0;
         if (w_timeout)        err_q  <= 1'b1;
         else if (w_resp_done) err_q  <= 1'b0;
      end
   end

   // In-flight beat tracking; an aborted drain forgets beats the tile lost.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         outst_q <= '0;
      end else if (w_timeout) begin
         outst_q <= '0;
      end else if (w_inc && !w_dec) begin
         outst_q <= outst_q + (LEN_W+1)'(1);
      end else if (!w_inc && w_dec) begin
         outst_q <= outst_q - (LEN_W+1)'(1);
      end
   end

   // Capture the tile result on every counted output beat.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i)    c_q <= '0;
      else if (w_dec) c_q <= bus_io.tile_out_c;
   end

   // Cycles spent in DRAIN since the last tile output.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i)                                           idle_q <= '0;
      else if (state_q != S_DRAIN || bus_io.tile_out_valid)  idle_q <= '0;
      else                                                   idle_q <= idle_q + IDLE_W'(1);
   end

`ifdef TILE_SEQ_PERF_EN
   logic [31:0] perf_q;

   // Saturating count of COMPUTE cycles with no operand offered.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         perf_q <= '0;
      end else if ((state_q == S_COMPUTE) && !bus_io.in_valid && (perf_q != '1)) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign perf_stall_cycles_o = perf_q;
`else
   // Stall counter not built; no extra state or port.
`endif

endmodule
`default_nettype wire

// File: tb/tb_tile_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tile_sequencer
//  Brief    : Self-checking bench for tile_sequencer with a latency-1 tile
//             model, a command vector table and a response scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tile_sequencer;
   localparam int A_W = 8, B_W = 19, C_W = 38, SHIFT_W = 4, LEN_W = 8;
   localparam int DRAIN_TIMEOUT = 16;

   logic clock_i = 1'b0;
   logic reset_i = 1'b1;
   logic busy;
   bit   tile_alive = 1'b1;
   logic [C_W-1:0] last_tile_c;
   logic [C_W-1:0] tile_c_next;
`ifdef TILE_SEQ_PERF_EN
   logic [31:0] perf;
`endif

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic               preload;
      logic [LEN_W-1:0]   len;
      logic [SHIFT_W-1:0] shift;
      logic [C_W-1:0]     d;
      logic [15:0]        pat;       // in_valid per compute cycle
      bit                 alive;     // tile produces outputs
      int                 hold;      // cycles resp_ready stays low
      logic [LEN_W-1:0]   exp_count;
      logic               exp_err;
      logic               exp_prop;
      int                 exp_pre;
      int                 exp_comp;
      int                 exp_drain; // -1: not checked
      int                 exp_wait;  // -1: not checked
      int                 exp_stall;
   } vec_t;

   typedef struct {
      logic [LEN_W-1:0] count;
      logic             err;
   } exp_t;

   vec_t vecs[7];
   exp_t sb[$];

   always #5 clock_i = ~clock_i;

   tile_sequencer_if #(.A_W(A_W), .B_W(B_W), .C_W(C_W), .SHIFT_W(SHIFT_W), .LEN_W(LEN_W)) bus ();

   tile_sequencer #(
      .A_W(A_W), .B_W(B_W), .C_W(C_W), .SHIFT_W(SHIFT_W), .LEN_W(LEN_W),
      .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
   ) dut (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .bus_io  (bus),
      .busy_o  (busy)
`ifdef TILE_SEQ_PERF_EN
      ,
      .perf_stall_cycles_o (perf)
`endif
   );

   // Tile model: one cycle latency, c = d + a*b + 7.
   assign tile_c_next = bus.tile_in_d + C_W'(bus.tile_in_a) * C_W'(bus.tile_in_b) + C_W'(7);

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         bus.tile_out_valid <= 1'b0;
         bus.tile_out_c     <= '0;
         last_tile_c        <= '0;
      end else begin
         bus.tile_out_valid <= bus.tile_in_valid && tile_alive;
         if (bus.tile_in_valid && tile_alive) begin
            bus.tile_out_c <= tile_c_next;
            last_tile_c    <= tile_c_next;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_cmd(input vec_t v);
      int k, cyc, n_pre, n_beats, n_comp, n_drain, bad_fwd, bad_ctl;
      bit got;
      exp_t e;
      logic [C_W-1:0] exp_c;
`ifdef TILE_SEQ_PERF_EN
      logic [31:0] perf0;
`endif
      tile_alive = v.alive;
      @(negedge clock_i);
      bus.cmd_valid   = 1'b1;
      bus.cmd_len     = v.len;
      bus.cmd_preload = v.preload;
      bus.cmd_shift   = v.shift;
      bus.cmd_d       = v.d;
      #1;
      check("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
`ifdef TILE_SEQ_PERF_EN
      perf0 = perf;
`endif
      sb.push_back('{count: v.exp_count, err: v.exp_err});
      @(posedge clock_i);
      @(negedge clock_i);
      bus.cmd_valid = 1'b0; bus.cmd_preload = 1'b0; bus.cmd_len = '0; bus.cmd_d = '0;
      k = 0; cyc = 0; got = 1'b0;
      n_pre = 0; n_beats = 0; n_comp = 0; n_drain = 0; bad_fwd = 0; bad_ctl = 0;
      while (!got && cyc < 300) begin
         if (bus.in_ready) begin
            bus.in_valid = v.pat[k % 16];
            bus.in_a     = A_W'($urandom);
            bus.in_b     = B_W'($urandom);
            k++;
         end else begin
            bus.in_valid = 1'b0;
         end
         #1;
         if (bus.resp_valid) begin
            got = 1'b1;
         end else begin
            if (bus.tile_in_control_propagate !== v.exp_prop || bus.tile_in_control_shift !== v.shift)
               bad_ctl++;
            if (bus.in_ready) begin
               n_comp++;
               if (bus.tile_in_valid) n_beats++;
               if (bus.tile_in_valid !== bus.in_valid || bus.tile_in_a !== bus.in_a ||
                   bus.tile_in_b !== bus.in_b || bus.tile_in_d !== '0)
                  bad_fwd++;
            end else if (bus.tile_in_valid) begin
               n_pre++;
               if (bus.tile_in_d !== v.d || bus.tile_in_a !== '0 || bus.tile_in_b !== '0) bad_fwd++;
            end else begin
               n_drain++;
            end
            @(posedge clock_i);
            @(negedge clock_i);
            cyc++;
         end
      end
      bus.in_valid = 1'b0;
      check("resp_seen", 64'(got), 64'd1);
      if (sb.size() == 0) begin
         check("scoreboard_nonempty", 64'(sb.size()), 64'd1);
         e = '{count: '0, err: 1'b0};
      end else begin
         e = sb.pop_front();
      end
      exp_c = last_tile_c;
      check("resp_count", 64'(bus.resp_count), 64'(e.count));
      check("resp_err",   64'(bus.resp_err),   64'(e.err));
      check("resp_c",     64'(bus.resp_c),     64'(exp_c));
      check("preload_cycles", 64'(n_pre),   64'(v.exp_pre));
      check("compute_cycles", 64'(n_comp),  64'(v.exp_comp));
      check("beats_forwarded", 64'(n_beats), 64'(v.len));
      check("tile_drive", 64'(bad_fwd), 64'd0);
      check("shift_prop", 64'(bad_ctl), 64'd0);
      if (v.exp_drain >= 0) check("drain_cycles", 64'(n_drain), 64'(v.exp_drain));
      if (v.exp_wait >= 0)  check("resp_latency", 64'(cyc), 64'(v.exp_wait));
`ifdef TILE_SEQ_PERF_EN
      check("perf_stall", 64'(perf - perf0), 64'(v.exp_stall));
`endif
      for (int h = 0; h < v.hold; h++) begin
         @(posedge clock_i);
         @(negedge clock_i);
         #1;
         check("hold_valid", 64'(bus.resp_valid), 64'd1);
         check("hold_count", 64'(bus.resp_count), 64'(e.count));
         check("hold_err",   64'(bus.resp_err),   64'(e.err));
         check("hold_c",     64'(bus.resp_c),     64'(exp_c));
      end
      bus.resp_ready = 1'b1;
      #1;
      check("cmd_ready_in_resp", 64'(bus.cmd_ready), 64'd0);
      @(posedge clock_i);
      @(negedge clock_i);
      bus.resp_ready = 1'b0;
      #1;
      check("idle_after_resp", {62'd0, busy, bus.resp_valid}, 64'd0);
      check("ready_after_resp", 64'(bus.cmd_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{preload:1'b1, len:8'd3, shift:4'd2, d:38'd5,  pat:16'hFFFF, alive:1'b1, hold:0,
                  exp_count:8'd3, exp_err:1'b0, exp_prop:1'b1, exp_pre:1, exp_comp:3,
                  exp_drain:-1, exp_wait:-1, exp_stall:0};
      vecs[1] = '{preload:1'b0, len:8'd2, shift:4'd9, d:38'h123, pat:16'hFFFF, alive:1'b1, hold:2,
                  exp_count:8'd2, exp_err:1'b0, exp_prop:1'b1, exp_pre:0, exp_comp:2,
                  exp_drain:-1, exp_wait:-1, exp_stall:0};
      vecs[2] = '{preload:1'b0, len:8'd4, shift:4'hA, d:38'd0, pat:16'hAAAA, alive:1'b1, hold:0,
                  exp_count:8'd4, exp_err:1'b0, exp_prop:1'b1, exp_pre:0, exp_comp:8,
                  exp_drain:-1, exp_wait:-1, exp_stall:4};
      vecs[3] = '{preload:1'b0, len:8'd0, shift:4'd3, d:38'd7, pat:16'hFFFF, alive:1'b1, hold:0,
                  exp_count:8'd0, exp_err:1'b0, exp_prop:1'b1, exp_pre:0, exp_comp:0,
                  exp_drain:0, exp_wait:0, exp_stall:0};
      vecs[4] = '{preload:1'b1, len:8'd0, shift:4'd5, d:38'h3_0000_0001, pat:16'hFFFF, alive:1'b1, hold:0,
                  exp_count:8'd0, exp_err:1'b0, exp_prop:1'b0, exp_pre:1, exp_comp:0,
                  exp_drain:-1, exp_wait:-1, exp_stall:0};
      vecs[5] = '{preload:1'b0, len:8'd1, shift:4'hF, d:38'd0, pat:16'hFFFF, alive:1'b0, hold:5,
                  exp_count:8'd1, exp_err:1'b1, exp_prop:1'b0, exp_pre:0, exp_comp:1,
                  exp_drain:DRAIN_TIMEOUT, exp_wait:-1, exp_stall:0};
      vecs[6] = '{preload:1'b0, len:8'd1, shift:4'd1, d:38'd0, pat:16'hFFFF, alive:1'b1, hold:0,
                  exp_count:8'd1, exp_err:1'b0, exp_prop:1'b0, exp_pre:0, exp_comp:1,
                  exp_drain:-1, exp_wait:-1, exp_stall:0};

      bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.cmd_preload = 1'b0;
      bus.cmd_shift = '0;   bus.cmd_d = '0;
      bus.in_valid = 1'b0;  bus.in_a = '0; bus.in_b = '0;
      bus.resp_ready = 1'b0;

      // Reset state
      @(negedge clock_i);
      @(negedge clock_i);
      #1;
      check("rst_busy",      64'(busy),               64'd0);
      check("rst_cmd_ready", 64'(bus.cmd_ready),      64'd1);
      check("rst_tile_valid", 64'(bus.tile_in_valid), 64'd0);
      check("rst_prop_shift", {59'd0, bus.tile_in_control_propagate, bus.tile_in_control_shift}, 64'd0);
      check("rst_resp", {bus.resp_c, bus.resp_count, bus.resp_valid, bus.resp_err}, 64'd0);
      reset_i = 1'b0;

      for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

      // Reset in the middle of COMPUTE after 2 of 4 beats (preload flips propagate to 1 first).
      tile_alive = 1'b1;
      @(negedge clock_i);
      bus.cmd_valid = 1'b1; bus.cmd_len = 8'd4; bus.cmd_preload = 1'b1;
      bus.cmd_shift = 4'd6; bus.cmd_d = 38'd9;
      @(posedge clock_i);
      @(negedge clock_i);
      bus.cmd_valid = 1'b0; bus.cmd_preload = 1'b0;
      #1;
      check("mid_prop_set", 64'(bus.tile_in_control_propagate), 64'd1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clock_i);
         bus.in_valid = 1'b1; bus.in_a = 8'h11; bus.in_b = 19'h222;
      end
      @(negedge clock_i);
      bus.in_valid = 1'b1;
      #1;
      check("mid_in_compute", 64'(bus.in_ready), 64'd1);
      #1;
      reset_i = 1'b1;
      #1;
      check("mid_rst_busy",  64'(busy),              64'd0);
      check("mid_rst_tile", {bus.tile_in_valid, bus.tile_in_a, bus.tile_in_b}, 64'd0);
      check("mid_rst_d",     64'(bus.tile_in_d),     64'd0);
      check("mid_rst_ctl", {59'd0, bus.tile_in_control_propagate, bus.tile_in_control_shift}, 64'd0);
      check("mid_rst_resp", {62'd0, bus.resp_valid, bus.in_ready}, 64'd0);
      bus.in_valid = 1'b0;
      @(negedge clock_i);
      reset_i = 1'b0;
      begin
         int resp_seen;
         resp_seen = 0;
         for (int i = 0; i < 8; i++) begin
            @(negedge clock_i);
            #1;
            if (bus.resp_valid || busy) resp_seen++;
         end
         check("mid_rst_no_resp", 64'(resp_seen), 64'd0);
      end

      // The sequencer works normally after the abandoned command.
      run_cmd(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/tile_sequencer.md
Name: tile_sequencer

Overview:
- Controller that sequences one systolic PE tile (8-bit a, 19-bit b, 38-bit d/c, propagate/shift control, valid) through one operation: optional preload of d, then a burst of a/b compute beats, then drain.
- Accepts one command at a time, streams operand beats into the tile and tracks in-flight beats against tile out_valid.
- Returns the last accumulated c with a beat count.
- Sits between the mesh-level controller and the tile instance.

Parameters:
- A_W, 8, width of a operand
- B_W, 19, width of b operand
- C_W, 38, width of d/c
- SHIFT_W, 4, width of control shift
- LEN_W, 8, width of beat count
- DRAIN_TIMEOUT, 16, max DRAIN cycles without tile_out_valid before abort

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer accepts command
- cmd_len  in  LEN_W  compute beats (0 = preload only)
- cmd_preload  in  1  perform d preload and flip propagate
- cmd_shift  in  SHIFT_W  shift applied for this command
- cmd_d  in  C_W  preload value
- in_valid  in  1  operand beat offered
- in_ready  out  1  operand beat accepted
- in_a  in  A_W  a operand
- in_b  in  B_W  b operand
- tile_in_a  out  A_W  to tile a
- tile_in_b  out  B_W  to tile b
- tile_in_d  out  C_W  to tile d
- tile_in_control_propagate  out  1  to tile propagate
- tile_in_control_shift  out  SHIFT_W  to tile shift
- tile_in_valid  out  1  to tile valid
- tile_out_c  in  C_W  from tile c
- tile_out_valid  in  1  from tile valid
- resp_valid  out  1  result available
- resp_ready  in  1  result consumed
- resp_c  out  C_W  last captured c
- resp_count  out  LEN_W  beats issued (compute only)
- resp_err  out  1  drain timeout occurred
- busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE; all outputs 0; propagate register 0; counters 0. Reset mid-operation abandons the command with no response.
- States: IDLE, PRELOAD, COMPUTE, DRAIN, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch len/shift/d/preload.
  - If cmd_preload=1: go to PRELOAD.
  - Else if len>0: go to COMPUTE.
  - Else: go to RESP.
- PRELOAD (1 cycle):
  - Propagate register toggles at entry and is driven from the next cycle onward.
  - Drive tile_in_d=latched d, a=0, b=0, tile_in_valid=1.
  - Next state: COMPUTE if len>0, else DRAIN.
- COMPUTE:
  - in_ready=1; tile_in_valid=in_valid; tile_in_a/b = in_a/b; tile_in_d=0.
  - Count accepted beats; after the len-th beat go to DRAIN.
  - in_valid=0 cycles stall with no counting.
- tile_in_a/b/d/valid are combinational from state and inputs (zero added latency). Shift and propagate are registered and stable for the whole command.
- Outstanding counter (LEN_W+1 bits):
  - +1 on tile_in_valid, -1 on tile_out_valid, unchanged when both occur.
  - tile_out_valid while the counter is 0 is ignored; it never underflows.
- Capture: tile_out_c is captured on every counted tile_out_valid. resp_c = last capture.
- DRAIN:
  - When outstanding==0, go to RESP.
  - Idle counter resets on each tile_out_valid. If it reaches DRAIN_TIMEOUT, set resp_err=1 and go to RESP.
- RESP:
  - resp_valid=1; resp_c/count/err held stable until resp_ready.
  - On the handshake: go to IDLE, clear err and the beat counter. cmd_ready stays 0 in that cycle.
- No back-to-back overlap: one command completes before the next is accepted.

Optional Feature:
- TILE_SEQ_PERF_EN defined:
  - Adds output perf_stall_cycles (32 bits), counting COMPUTE cycles with in_valid=0.
  - Saturates at all-ones.
  - Cleared by reset only.
- Not defined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset mid-COMPUTE (after 2 of 4 beats) -> all outputs 0, state IDLE, propagate 0, no response issued.
- Preload d=5, len=3, shift=2, tile latency 1, beats every cycle:
  - tile_in_d=5 for exactly 1 cycle, propagate 0->1, then 3 tile_in_valid beats.
  - resp_count=3, resp_c = last tile_out_c, resp_err=0.
- Second command with cmd_preload=0, len=2 -> propagate stays 1, shift latched anew, resp_count=2.
- len=4 with in_valid toggling 1,0,1,0,... -> exactly 4 beats forwarded, COMPUTE lasts 8 cycles, perf_stall_cycles=4 (TILE_SEQ_PERF_EN).
- Tile never asserts out_valid after 1 beat -> RESP after 16 DRAIN cycles with resp_err=1. Holding resp_ready=0 for 5 cycles keeps resp_* stable.
- cmd_len=0, cmd_preload=0 -> IDLE->RESP next cycle, resp_count=0, no tile_in_valid asserted.
